// File: rtl/ram_burst_reader.sv
// ram_burst_reader: streams a burst of words out of a single-port RAM.
//
// A request (io_start with io_base/io_len) reads io_len consecutive words
// from io_base. The address wraps modulo 2^ADDR_WIDTH. Words go through a
// 2-entry FIFO onto a valid/ready stream. Reads are throttled so that buffered
// words plus reads in flight never exceed the FIFO depth.
//
// Optional feature, macro CLEAR_AFTER_READ_EN: every read at address A is
// followed by a write of zero to A. The FSM then alternates READ/CLEAR.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   io_start/base/len     burst request, sampled only while idle
//   io_busy, io_done      not-idle flag, completion pulse
//   io_valid/ready/data   output word stream
//   ram_rd/wr/addr/mask   RAM initiator, 1-cycle read latency
//   ram_din/dout          RAM write data / read data
module ram_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic [ADDR_WIDTH-1:0] io_base,
  input  logic [ADDR_WIDTH-1:0] io_len,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_valid,
  input  logic                  io_ready,
  output logic [DATA_WIDTH-1:0] io_data,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [1:0]            ram_mask,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

`ifdef CLEAR_AFTER_READ_EN
  typedef enum logic [1:0] {StIdle, StRead, StDrain, StClear} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;
`endif

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rem_q;       // reads still to be issued
  logic                  inflight_q;  // read issued last cycle, data on ram_dout now
  logic                  done_q;      // zero-length completion pulse
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic       pop;
  logic [1:0] occ_net;
  logic [1:0] committed;
  logic       last_xfer;

  always_comb begin
    io_valid  = (count_q != 2'd0);
    pop       = io_valid & io_ready;
    // Occupancy net of the word leaving this cycle: a slot freed by a pop can
    // be refilled two cycles later, which keeps one word per cycle flowing.
    occ_net   = count_q - {1'b0, pop};
    committed = occ_net + {1'b0, inflight_q};
    ram_rd    = (state_q == StRead) && (committed < 2'd2);
    last_xfer = (state_q == StDrain) && !inflight_q && (count_q == 2'd1) && pop;
    io_done   = done_q | last_xfer;
    io_busy   = (state_q != StIdle);
    io_data   = fifo_q[rd_ptr_q];
    ram_addr  = addr_q;
    ram_mask  = 2'b11;
    ram_din   = '0;
`ifdef CLEAR_AFTER_READ_EN
    ram_wr    = (state_q == StClear);
`else
    ram_wr    = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= ram_rd;

      // Capture and pop may coincide; both take effect.
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};

      unique case (state_q)
        StIdle: begin
          if (io_start) begin
            if (io_len != '0) begin
              addr_q  <= io_base;
              rem_q   <= io_len;
              state_q <= StRead;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRead: begin
          if (ram_rd) begin
            rem_q <= rem_q - 1'b1;
`ifdef CLEAR_AFTER_READ_EN
            // Address advances after the matching clear write.
            state_q <= StClear;
`else
            addr_q <= addr_q + 1'b1;
            if (rem_q == ADDR_WIDTH'(1)) begin
              state_q <= StDrain;
            end
`endif
          end
        end
`ifdef CLEAR_AFTER_READ_EN
        StClear: begin
          addr_q  <= addr_q + 1'b1;
          state_q <= (rem_q == '0) ? StDrain : StRead;
        end
`endif
        StDrain: begin
          if (last_xfer) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: behavioural RAM (word i reads 0x1000+i until
// written), scoreboard queues for stream data and RAM accesses, one checker.
module tb_ram_burst_reader;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef CLEAR_AFTER_READ_EN
  localparam bit RATE = 1'b0;
`else
  localparam bit RATE = 1'b1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_start = 1'b0;
  logic          io_ready = 1'b0;
  logic [AW-1:0] io_base = '0;
  logic [AW-1:0] io_len = '0;
  logic          io_busy, io_done, io_valid;
  logic [DW-1:0] io_data;
  logic          ram_rd, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_mask;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  bit            wr_valid [DEPTH];
  logic [DW-1:0] wr_data  [DEPTH];

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_data_q [$];
  logic [AW:0]   exp_acc_q  [$];   // {is_write, address}
  int            done_seen = 0;
  bit            mon_en = 1'b0;
  bit            done_xfer_exp = 1'b1;
  int            outstanding = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW:0]   acc;
  logic [DW-1:0] dexp;

  ram_burst_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .io_start(io_start),
    .io_base (io_base),
    .io_len  (io_len),
    .io_busy (io_busy),
    .io_done (io_done),
    .io_valid(io_valid),
    .io_ready(io_ready),
    .io_data (io_data),
    .ram_rd  (ram_rd),
    .ram_wr  (ram_wr),
    .ram_addr(ram_addr),
    .ram_mask(ram_mask),
    .ram_din (ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Single-port RAM, 1-cycle read latency.
  always @(posedge clock) begin
    if (ram_rd) begin
      ram_dout <= wr_valid[ram_addr] ? wr_data[ram_addr] : 16'h1000 + DW'(ram_addr);
    end
    if (ram_wr) begin
      wr_valid[ram_addr] <= 1'b1;
      wr_data[ram_addr]  <= ram_din;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (io_done) done_seen++;
    if (mon_en) begin
      check_eq("rd_wr_excl", 32'(ram_rd & ram_wr), 32'd0);
`ifdef CLEAR_AFTER_READ_EN
      if (ram_wr) check_eq("clr_word", 32'({ram_mask, ram_din}), 32'({2'b11, 16'h0}));
`else
      check_eq("wr_idle", 32'({ram_wr, ram_mask, ram_din}), 32'({1'b0, 2'b11, 16'h0}));
`endif
      if (ram_rd || ram_wr) begin
        if (exp_acc_q.size() == 0) begin
          check_eq("acc_extra", 32'({ram_wr, ram_addr}), 32'hFFFF_FFFF);
        end else begin
          acc = exp_acc_q.pop_front();
          check_eq("ram_acc", 32'({ram_wr, ram_addr}), 32'(acc));
        end
      end
      check_eq("occupancy", 32'(outstanding <= 2), 32'd1);
      if (prev_stall) check_eq("stall_hold", 32'({io_valid, io_data}), 32'({1'b1, prev_data}));
      if (io_valid && io_ready) begin
        if (exp_data_q.size() == 0) begin
          check_eq("data_extra", 32'(io_data), 32'hFFFF_FFFF);
        end else begin
          dexp = exp_data_q.pop_front();
          check_eq("data", 32'(io_data), 32'(dexp));
        end
        outstanding--;
      end
      if (ram_rd) outstanding++;
      if (io_done) check_eq("done_xfer", 32'(io_valid && io_ready), 32'(done_xfer_exp));
      prev_stall = io_valid && !io_ready;
      prev_data  = io_data;
    end
  end

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating.
  task automatic run_burst(input logic [AW-1:0] base, input int len, input int mode,
                           input bit exp_zero, input bit check_rate);
    int first;
    int done_at;
    int d0;
    logic [AW-1:0] a;
    first   = -1;
    done_at = -1;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      exp_data_q.push_back(exp_zero ? 16'h0 : 16'h1000 + DW'(a));
      exp_acc_q.push_back({1'b0, a});
`ifdef CLEAR_AFTER_READ_EN
      exp_acc_q.push_back({1'b1, a});
`endif
    end
    done_xfer_exp = (len != 0);
    d0 = done_seen;
    @(posedge clock); #1;
    io_start = 1'b1;
    io_base  = base;
    io_len   = AW'(len);
    io_ready = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      io_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge clock);
      if (io_valid && first < 0) first = cyc;
      if (io_done) begin
        done_at = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    if (done_at < 0) check_eq("timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    check_eq("done_once", 32'(done_seen - d0), 32'd1);
    check_eq("left_data", 32'(exp_data_q.size()), 32'd0);
    check_eq("left_acc", 32'(exp_acc_q.size()), 32'd0);
    check_eq("idle_after", 32'(io_busy), 32'd0);
    if (len == 0) begin
      check_eq("zero_done_at", 32'(done_at), 32'd1);
      check_eq("zero_no_valid", 32'(first), 32'hFFFF_FFFF);
    end else if (check_rate) begin
      // io_start sampled at edge 1; first word visible after edge 3.
      check_eq("latency", 32'(first - 1), 32'd2);
      check_eq("rate", 32'(done_at - first), 32'(len - 1));
    end
    exp_data_q.delete();
    exp_acc_q.delete();
  endtask

  task automatic abort_test();
    int d0;
    mon_en = 1'b0;
    @(posedge clock); #1;
    io_start = 1'b1;
    io_base  = 15'd20;
    io_len   = 15'd16;
    io_ready = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    d0 = done_seen;
    @(posedge clock); #1;
    check_eq("abort_flags", 32'({io_busy, io_done, io_valid, ram_rd, ram_wr}), 32'd0);
    check_eq("abort_addr", 32'(ram_addr), 32'd0);
    check_eq("abort_data", 32'(io_data), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("abort_nodone", 32'(done_seen - d0), 32'd0);
    check_eq("abort_dropped", 32'({io_valid, io_busy}), 32'd0);
    outstanding = 0;
    prev_stall  = 1'b0;
    mon_en      = 1'b1;
    run_burst(15'd50, 2, 0, 1'b0, RATE);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_flags", 32'({io_busy, io_done, io_valid, ram_rd, ram_wr}), 32'd0);
    check_eq("rst_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_data", 32'(io_data), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    run_burst(15'd4, 8, 0, 1'b0, RATE);
    run_burst(15'h7FFE, 4, 0, 1'b0, RATE);
    run_burst(15'd100, 8, 1, 1'b0, 1'b0);
    run_burst(15'd200, 0, 0, 1'b0, 1'b0);
    abort_test();
`ifdef CLEAR_AFTER_READ_EN
    run_burst(15'd0, 4, 0, 1'b0, 1'b0);
    run_burst(15'd0, 4, 0, 1'b1, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 15, which sets the RAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, which sets the RAM word width.
REQ-003 Port clock, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port io_start, input, 1 bit: one-cycle burst request, sampled only in IDLE.
REQ-006 Port io_base, input, ADDR_WIDTH bits: first word address, captured with io_start.
REQ-007 Port io_len, input, ADDR_WIDTH bits: word count, captured with io_start.
REQ-008 Port io_busy, output, 1 bit: high in any state other than IDLE.
REQ-009 Port io_done, output, 1 bit: one-cycle pulse at burst completion.
REQ-010 Port io_valid, output, 1 bit: stream data valid.
REQ-011 Port io_ready, input, 1 bit: stream data accepted by the consumer.
REQ-012 Port io_data, output, DATA_WIDTH bits: stream data word.
REQ-013 Ports ram_rd, ram_wr (output, 1 bit), ram_addr (output, ADDR_WIDTH), ram_mask (output, 2), ram_din (output, DATA_WIDTH), ram_dout (input, DATA_WIDTH): initiator side of a single-port RAM with 1-cycle read latency.

Function
REQ-014 The FSM SHALL have three states: IDLE, READ and DRAIN, plus CLEAR when the macro is defined.
REQ-015 IDLE with io_start=1 and io_len!=0 SHALL capture base and len and go to READ on the next cycle.
REQ-016 IDLE with io_start=1 and io_len=0 SHALL stay in IDLE and pulse io_done on the next cycle; no RAM access is made.
REQ-017 io_start SHALL be ignored while io_busy=1.
REQ-018 In READ, ram_rd SHALL be asserted only when (buffer occupancy + reads in flight) < 2.
REQ-019 Each issued read SHALL use the current address; the address then increments and wraps modulo 2^ADDR_WIDTH (0x7FFF -> 0x0000).
REQ-020 ram_dout SHALL be captured into the 2-entry output FIFO exactly one cycle after its ram_rd.
REQ-021 Words SHALL leave the FIFO in address order; io_data SHALL be the FIFO head and io_valid SHALL equal FIFO non-empty.
REQ-022 A word is transferred when io_valid&&io_ready; io_data SHALL stay stable while io_valid=1 and io_ready=0.
REQ-023 A capture and a pop in the same cycle SHALL both take effect and leave occupancy unchanged; the FIFO SHALL never overflow.
REQ-024 The FSM SHALL go READ -> DRAIN after the last read is issued.
REQ-025 In DRAIN, when the last word transfers, io_done SHALL pulse that same cycle and the FSM SHALL enter IDLE on the next cycle.
REQ-026 Without CLEAR_AFTER_READ_EN, ram_wr=0, ram_mask=2'b11 and ram_din=0 at all times.
REQ-027 Throughput with io_ready held high SHALL be 1 word/cycle after a 2-cycle start latency (io_start to first io_valid).
REQ-028 ram_rd and ram_wr SHALL never be high in the same cycle.

Reset
REQ-029 Reset SHALL force IDLE, empty the FIFO and discard any in-flight read.
REQ-030 After reset, io_busy, io_done, io_valid, ram_rd and ram_wr SHALL be 0, and ram_addr and io_data SHALL be 0.
REQ-031 Reset mid-burst SHALL abort the burst with no io_done pulse; a read returning after reset SHALL be dropped.

Configuration
REQ-032 With CLEAR_AFTER_READ_EN defined, each read at address A SHALL be followed on the next cycle by a CLEAR cycle: ram_wr=1, ram_addr=A, ram_mask=2'b11, ram_din=0.
REQ-033 With the macro defined, the FSM SHALL alternate READ/CLEAR (0.5 word/cycle peak), and the last CLEAR SHALL be done before entering DRAIN.
REQ-034 Without the macro, the CLEAR state and its logic SHALL be absent and REQ-026 SHALL apply.

Verification
REQ-035 RAM preloaded with 0x1000+i at address i; start base=4, len=8, ready=1 -> io_data 0x1004..0x100B on 8 consecutive cycles, io_done coincident with the last transfer.
REQ-036 base=0x7FFE, len=4 -> ram_addr sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001, and the data order matches.
REQ-037 len=8 with io_ready toggling 1,0,0,1 repeating -> all 8 words in order with none dropped or duplicated, occupancy never above 2, io_data stable during stalls.
REQ-038 len=0 -> io_done pulses 1 cycle later, with no ram_rd and no io_valid.
REQ-039 Reset asserted 3 cycles into a len=16 burst -> all outputs 0 on the next cycle and no io_done; a new start with len=2 then completes normally.
REQ-040 With CLEAR_AFTER_READ_EN, base=0, len=4 -> reads then zero writes alternate at 0,0,1,1,2,2,3,3; a second burst over the same range returns 0x0000 x4.
